// File: rtl/pipelined_control_unit.sv
// RV32I five-stage control path: ID decode, ID/EX, EX/MEM and MEM/WB control registers, EX branch resolution.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to flag illegal instructions through to illegal_w.
module pipelined_control_unit #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned IMM_SRC_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op_d,
    input  logic [2:0]            funct3_d,
    input  logic                  funct7_5_d,
    input  logic                  flush_e,
    input  logic                  zero_e,
    input  logic                  lt_e,
    input  logic                  ltu_e,
    output logic [IMM_SRC_W-1:0]  imm_src_d,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
    output logic                  alu_src_e,
    output logic                  alu_a_pc_e,
    output logic                  pc_src_e,
    output logic                  jalr_e,
    output logic                  mem_write_m,
    output logic [2:0]            funct3_m,
    output logic                  reg_write_m,
    output logic [1:0]            result_src_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic                  illegal_w
);
    localparam int unsigned ALU_W = 4;
    localparam int unsigned IMM_W = 3;
    localparam int unsigned RES_W = 2;
    localparam int unsigned F3_W  = 3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd9;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    localparam logic [RES_W-1:0] RES_ALU = 2'b00;
    localparam logic [RES_W-1:0] RES_MEM = 2'b01;
    localparam logic [RES_W-1:0] RES_PC4 = 2'b10;
    localparam logic [RES_W-1:0] RES_IMM = 2'b11;

    typedef struct packed {
        logic             reg_write;
        logic [RES_W-1:0] result_src;
        logic             mem_write;
        logic             branch;
        logic             jump;
        logic             jalr;
        logic [ALU_W-1:0] alu_ctrl;
        logic             alu_src;
        logic             alu_a_pc;
        logic [F3_W-1:0]  funct3;
        logic             illegal;
    } ex_ctrl_t;

    typedef struct packed {
        logic             reg_write;
        logic [RES_W-1:0] result_src;
        logic             mem_write;
        logic [F3_W-1:0]  funct3;
        logic             illegal;
    } mem_ctrl_t;

    typedef struct packed {
        logic             reg_write;
        logic [RES_W-1:0] result_src;
        logic             illegal;
    } wb_ctrl_t;

    ex_ctrl_t         dec;
    logic [IMM_W-1:0] imm_src;
    logic             known_op;
    ex_ctrl_t         ex_q;
    mem_ctrl_t        mem_q;
    wb_ctrl_t         wb_q;
    logic             br_cond;

    // alt selects sub (funct3 000) or sra (funct3 101)
    function automatic logic [ALU_W-1:0] alu_from_f3(input logic [F3_W-1:0] f3, input logic alt);
        logic [ALU_W-1:0] a;
        case (f3)
            3'b000:  a = alt ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = alt ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    // ID decode
    always_comb begin
        dec        = '0;
        imm_src    = IMM_I;
        known_op   = 1'b1;
        dec.funct3 = funct3_d;
        case (op_d)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = IMM_S;
            end
            OP_R: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_ALU;
                dec.alu_ctrl   = alu_from_f3(funct3_d, funct7_5_d);
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_from_f3(funct3_d, funct7_5_d & (funct3_d == 3'b101));
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                imm_src      = IMM_B;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
                imm_src        = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_IMM;
                imm_src        = IMM_U;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_a_pc  = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = IMM_U;
            end
            default: known_op = 1'b0;
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!known_op || (op_d == OP_R && funct7_5_d &&
                          funct3_d != 3'b000 && funct3_d != 3'b101)) begin
            dec         = '0;
            dec.illegal = 1'b1;
            imm_src     = IMM_I;
        end
`else
        if (!known_op) begin
            dec     = '0;
            imm_src = IMM_I;
        end
`endif
    end

    // Stage registers; flush_e only bubbles ID/EX, downstream keeps advancing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q             <= flush_e ? '0 : dec;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.result_src <= ex_q.result_src;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.funct3     <= ex_q.funct3;
            mem_q.illegal    <= ex_q.illegal;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_q.result_src  <= mem_q.result_src;
            wb_q.illegal     <= mem_q.illegal;
        end
    end

    // Branch resolution in EX
    always_comb begin
        br_cond = 1'b0;
        case (ex_q.funct3)
            3'b000:  br_cond = zero_e;
            3'b001:  br_cond = ~zero_e;
            3'b100:  br_cond = lt_e;
            3'b101:  br_cond = ~lt_e;
            3'b110:  br_cond = ltu_e;
            3'b111:  br_cond = ~ltu_e;
            default: br_cond = 1'b0;
        endcase
        pc_src_e = ex_q.jump | (ex_q.branch & br_cond);
    end

    assign imm_src_d    = IMM_SRC_W'(imm_src);
    assign alu_ctrl_e   = ALU_CTRL_W'(ex_q.alu_ctrl);
    assign alu_src_e    = ex_q.alu_src;
    assign alu_a_pc_e   = ex_q.alu_a_pc;
    assign jalr_e       = ex_q.jalr;
    assign mem_write_m  = mem_q.mem_write;
    assign funct3_m     = mem_q.funct3;
    assign reg_write_m  = mem_q.reg_write;
    assign result_src_m = mem_q.result_src;
    assign reg_write_w  = wb_q.reg_write;
    assign result_src_w = wb_q.result_src;
    assign illegal_w    = wb_q.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: directed scenarios plus randomized instruction stream.
module tb_pipelined_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op_d = '0;
    logic [2:0] funct3_d = '0;
    logic       funct7_5_d = 1'b0;
    logic       flush_e = 1'b0;
    logic       zero_e = 1'b0;
    logic       lt_e = 1'b0;
    logic       ltu_e = 1'b0;
    logic [2:0] imm_src_d;
    logic [3:0] alu_ctrl_e;
    logic       alu_src_e, alu_a_pc_e, pc_src_e, jalr_e;
    logic       mem_write_m, reg_write_m, reg_write_w, illegal_w;
    logic [2:0] funct3_m;
    logic [1:0] result_src_m, result_src_w;

    pipelined_control_unit #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) dut (
        .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7_5_d(funct7_5_d),
        .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(imm_src_d), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e),
        .alu_a_pc_e(alu_a_pc_e), .pc_src_e(pc_src_e), .jalr_e(jalr_e),
        .mem_write_m(mem_write_m), .funct3_m(funct3_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .reg_write_w(reg_write_w),
        .result_src_w(result_src_w), .illegal_w(illegal_w)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw;
        logic [1:0] res;
        logic       mw;
        logic       br;
        logic       jmp;
        logic       jr;
        logic [3:0] alu;
        logic       asrc;
        logic       apc;
        logic [2:0] f3;
        logic       ill;
        logic [2:0] imm;
    } rec_t;

    // ALU code per funct3, nibble i = funct3 i (add, sll, slt, sltu, xor, srl, or, and)
    localparam logic [31:0] ALU_TAB = {4'd2, 4'd3, 4'd8, 4'd4, 4'd6, 4'd5, 4'd7, 4'd0};

    rec_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [6:0] op_list [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        rec_t r;
        logic known;
        logic [3:0] base;
        r     = '0;
        r.f3  = f3;
        known = 1'b1;
        base  = ALU_TAB[4*int'(f3) +: 4];
        case (op)
            7'b0000011: begin r.rw = 1; r.asrc = 1; r.res = 2'b01; end
            7'b0100011: begin r.mw = 1; r.asrc = 1; r.imm = 3'd1; end
            7'b0110011: begin r.rw = 1; r.alu = base + 4'((f7 && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0); end
            7'b0010011: begin r.rw = 1; r.asrc = 1; r.alu = base + 4'((f7 && f3 == 3'd5) ? 1 : 0); end
            7'b1100011: begin r.br = 1; r.imm = 3'd2; r.alu = 4'd1; end
            7'b1101111: begin r.rw = 1; r.jmp = 1; r.res = 2'b10; r.imm = 3'd3; end
            7'b1100111: begin r.rw = 1; r.jmp = 1; r.jr = 1; r.asrc = 1; r.res = 2'b10; end
            7'b0110111: begin r.rw = 1; r.res = 2'b11; r.imm = 3'd4; end
            7'b0010111: begin r.rw = 1; r.apc = 1; r.asrc = 1; r.imm = 3'd4; end
            default:    known = 1'b0;
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!known || (op == 7'b0110011 && f7 && f3 != 3'd0 && f3 != 3'd5)) begin
            r = '0;
            r.ill = 1'b1;
        end
`else
        if (!known) r = '0;
`endif
        return r;
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        case (f3)
            3'd0: return z;      // beq
            3'd1: return !z;     // bne
            3'd4: return l;      // blt
            3'd5: return !l;     // bge
            3'd6: return lu;     // bltu
            3'd7: return !lu;    // bgeu
            default: return 1'b0;
        endcase
    endfunction

    // Issue one ID instruction (flags belong to what is currently in EX); called at posedge+1
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic fl, input logic z, input logic l, input logic lu);
        rec_t r;
        op_d = op; funct3_d = f3; funct7_5_d = f7; flush_e = fl;
        zero_e = z; lt_e = l; ltu_e = lu;
        #1;
        r = model(op, f3, f7);
        chk("imm_src_d", 32'(imm_src_d), 32'(r.imm));
        if (fl) r = '0;
        @(posedge clk);
        sbq.push_back(r);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        zero_e = 1'b1; lt_e = 1'b1; ltu_e = 1'b1;
        sbq.delete();
        #1;
        chk("rst_pc_src", 32'(pc_src_e), 32'd0);
        chk("rst_outs", {alu_ctrl_e, alu_src_e, alu_a_pc_e, jalr_e, mem_write_m, funct3_m,
                         reg_write_m, result_src_m, reg_write_w, result_src_w, illegal_w}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops one expected EX record per clock and shifts it down the modelled pipe
    rec_t ex_prev = '0, mem_e = '0, wb_e = '0;
    always @(negedge clk) begin
        rec_t ex_e;
        if (rst) begin
            chk("rst_hold", {alu_ctrl_e, alu_src_e, alu_a_pc_e, pc_src_e, jalr_e, mem_write_m,
                             reg_write_m, reg_write_w, illegal_w}, 32'd0);
            ex_prev = '0; mem_e = '0; wb_e = '0;
        end else if (sbq.size() > 0) begin
            ex_e    = sbq.pop_front();
            wb_e    = mem_e;
            mem_e   = ex_prev;
            ex_prev = ex_e;
            chk("alu_ctrl_e", 32'(alu_ctrl_e), 32'(ex_e.alu));
            chk("alu_src_e", 32'(alu_src_e), 32'(ex_e.asrc));
            chk("alu_a_pc_e", 32'(alu_a_pc_e), 32'(ex_e.apc));
            chk("jalr_e", 32'(jalr_e), 32'(ex_e.jr));
            chk("pc_src_e", 32'(pc_src_e),
                32'(ex_e.jmp | (ex_e.br & taken(ex_e.f3, zero_e, lt_e, ltu_e))));
            chk("mem_write_m", 32'(mem_write_m), 32'(mem_e.mw));
            chk("funct3_m", 32'(funct3_m), 32'(mem_e.f3));
            chk("reg_write_m", 32'(reg_write_m), 32'(mem_e.rw));
            chk("result_src_m", 32'(result_src_m), 32'(mem_e.res));
            chk("reg_write_w", 32'(reg_write_w), 32'(wb_e.rw));
            chk("result_src_w", 32'(result_src_w), 32'(wb_e.res));
            chk("illegal_w", 32'(illegal_w), 32'(wb_e.ill));
        end
    end

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, B = 7'b1100011;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // jal in EX when reset rises mid-cycle, then lw first after reset
        step(7'b1101111, 3'd0, 0, 0, 0, 0, 0);
        do_reset();
        step(7'b0000011, 3'd2, 0, 0, 0, 0, 0);
        repeat (3) step(I, 3'd0, 0, 0, 0, 0, 0);
        // add, sub, sra, srai, slli
        step(R, 3'd0, 0, 0, 0, 0, 0);
        step(R, 3'd0, 1, 0, 0, 0, 0);
        step(R, 3'd5, 1, 0, 0, 0, 0);
        step(I, 3'd5, 1, 0, 0, 0, 0);
        step(I, 3'd1, 0, 0, 0, 0, 0);
        step(I, 3'd0, 1, 0, 0, 0, 0);
        // bne, bgeu, blt, funct3 010; flags for each arrive with the following issue
        step(B, 3'd1, 0, 0, 0, 0, 0);
        step(B, 3'd7, 0, 0, 0, 0, 0);
        step(B, 3'd4, 0, 0, 0, 0, 1);
        step(B, 3'd2, 0, 0, 0, 1, 0);
        step(I, 3'd0, 0, 0, 1, 1, 1);
        // jalr, then sw followed by a flushed lw
        step(7'b1100111, 3'd0, 0, 0, 0, 0, 0);
        step(7'b0100011, 3'd2, 0, 0, 0, 0, 0);
        step(7'b0000011, 3'd2, 0, 1, 0, 0, 0);
        repeat (3) step(I, 3'd0, 0, 0, 0, 0, 0);
        // unknown opcode and illegal R-type encoding
        step(7'b0000000, 3'd0, 0, 0, 0, 0, 0);
        step(R, 3'd1, 1, 0, 0, 0, 0);
        step(7'b0000000, 3'd3, 0, 1, 0, 0, 0);
        repeat (4) step(I, 3'd0, 0, 0, 0, 0, 0);
        // randomized stream
        for (int i = 0; i < 1500; i++) begin
            logic [6:0] op;
            if ($urandom_range(0, 199) == 0) do_reset();
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_list[$urandom_range(0, 8)];
            step(op, 3'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                 1'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (3) step(I, 3'd0, 0, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
